// File: rtl/serial_add_sub_pkg.sv
// Shared encodings for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one full_adder cell, LSB first, WIDTH cycles per operation.
// state | meaning
// IDLE  | waiting for start (encoding 2'd3 also behaves as IDLE)
// RUN   | one operand bit per clock through the adder cell
// DONE  | one-cycle result-valid pulse; a new start is accepted here too
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    state_t             state;
    logic [WIDTH-1:0]   sh_a;
    logic [WIDTH-1:0]   sh_b;
    logic [WIDTH-2:0]   res_sh;
    logic               carry_ff;
    logic               c_msb_in;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   res_next;

    full_adder u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry_ff),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Sum bits enter at the top; after the last bit the full word is aligned.
    assign res_next = {fa_sum, res_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            res_sh    <= '0;
            carry_ff  <= 1'b0;
            c_msb_in  <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    sh_a     <= sh_a >> 1;
                    sh_b     <= sh_b >> 1;
                    res_sh   <= res_next[WIDTH-1:1];
                    carry_ff <= fa_cout;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 2))
                        c_msb_in <= fa_cout;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result    <= res_next;
                        carry_out <= fa_cout;
                        overflow  <= c_msb_in ^ fa_cout;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a     <= a;
                        sh_b     <= (op == OP_SUB) ? ~b : b;
                        carry_ff <= op;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub against an arithmetic reference model.
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prev_result = '0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Returns {overflow, carry_out, result} computed with plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        int ux, uy, sx, sy, sr;
        logic [W-1:0] r;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        if (o == 1'b0) begin
            r  = W'(ux + uy);
            c  = (ux + uy) >= (1 << W);
            sr = sx + sy;
        end else begin
            r  = W'(ux - uy);
            c  = ux >= uy;
            sr = sx - sy;
        end
        v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {v, c, r};
    endfunction

    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit keep, input bit interfere);
        logic [W+1:0] exp;
        int cyc;
        bit seen;
        exp = model(o, x, y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL accept: busy=%b done=%b required busy=1 done=0", busy, done);
        end
        checks++;
        if (result !== prev_result) begin
            errors++;
            $display("FAIL result_hold: result=%h required %h", result, prev_result);
        end
        seen = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 3 * W && !seen; i++) begin
            if (interfere && i == 3) begin
                start = 1'b1; op = ~o; a = ~x; b = y + 8'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc = i;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc != W) begin
            errors++;
            $display("FAIL latency: seen=%0d cycles=%0d required %0d", seen, cyc, W);
        end
        checks++;
        if (result !== exp[W-1:0]) begin
            errors++;
            $display("FAIL result: op=%b a=%h b=%h got %h required %h", o, x, y, result, exp[W-1:0]);
        end
        checks++;
        if (carry_out !== exp[W]) begin
            errors++;
            $display("FAIL carry_out: op=%b a=%h b=%h got %b required %b", o, x, y, carry_out, exp[W]);
        end
        checks++;
        if (overflow !== exp[W+1]) begin
            errors++;
            $display("FAIL overflow: op=%b a=%h b=%h got %b required %b", o, x, y, overflow, exp[W+1]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done: busy=%b required 0", busy);
        end
        prev_result = exp[W-1:0];
        if (!keep) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done=%b busy=%b required 0 0", done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, carry_out, overflow} !== 4'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b co=%b ov=%b result=%h required all 0",
                     busy, done, carry_out, overflow, result);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || result !== '0) begin
            errors++;
            $display("FAIL idle_no_start: busy=%b done=%b result=%h required 0 0 00", busy, done, result);
        end
        prev_result = '0;
    endtask

    task automatic test_directed();
        run_op(1'b0, 8'h2D, 8'h17, 1'b0, 1'b0);
        run_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op(1'b1, 8'h05, 8'h07, 1'b0, 1'b0);
        run_op(1'b1, 8'h80, 8'h01, 1'b0, 1'b0);
        run_op(1'b1, 8'h33, 8'h33, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_op(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
        run_op(1'b1, 8'h40, 8'hC1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 8'h5A, 8'h21, 1'b1, 1'b0);
        run_op(1'b1, 8'h10, 8'h20, 1'b1, 1'b0);
        run_op(1'b0, 8'h64, 8'h64, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        op = 1'b0; a = 8'h11; b = 8'h22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, carry_out, overflow} !== 4'b0 || result !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: busy=%b done=%b co=%b ov=%b result=%h required all 0",
                     busy, done, carry_out, overflow, result);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        prev_result = '0;
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL no_done_after_reset: activity seen=%0d required 0", seen);
        end
        run_op(1'b1, 8'h9C, 8'h3E, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
